acc_issue_tracker: RTL and testbench
====================================

ACC_ISSUE_TRACKER -- requirements
Module: acc_issue_tracker

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand/result width.
REQ-002 SHALL have parameter PayloadWidth, default 136, opaque request payload width (addr, id, op, operands).
REQ-003 SHALL have parameter MaxOutstanding, default 4, maximum in-flight writeback requests (>=1).
REQ-004 SHALL have parameter NumRegs, default 32, register-file size; RdWidth = clog2(NumRegs).
REQ-005 SHALL have port clk_i, input, 1, clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset rst_n, asynchronous, active-high.
REQ-007 SHALL have ports s_q_valid/s_q_ready, in/out, 1 each, core-side request handshake.
REQ-008 SHALL have ports s_q_payload in PayloadWidth, s_q_rd in RdWidth, s_q_wb in 1 (response expected), s_q_dual in 1 (writes rd and rd+1).
REQ-009 SHALL have ports m_q_valid/m_q_ready, out/in, 1 each, and m_q_payload out PayloadWidth, towards the interconnect master port.
REQ-010 SHALL have ports m_p_valid in, m_p_ready out, m_p_data0/m_p_data1 in DataWidth, m_p_rd in RdWidth, m_p_dual in 1, m_p_error in 1, response from interconnect.
REQ-011 SHALL have ports s_p_valid out, s_p_ready in, s_p_data0/s_p_data1 out DataWidth, s_p_rd out RdWidth, s_p_dual out 1, s_p_error out 1, response to core.
REQ-012 SHALL have ports flush_i in 1, flush_done_o out 1, busy_o out 1, err_o out 1, outstanding_o out clog2(MaxOutstanding+1), pending_o out NumRegs.

Function
REQ-013 SHALL compute stall = (outstanding==MaxOutstanding & s_q_wb) | hazard | fsm!=IDLE; hazard = s_q_wb & (pend[s_q_rd] | (s_q_dual & pend[(s_q_rd+1) mod NumRegs])).
REQ-014 SHALL drive m_q_valid = s_q_valid & ~stall, s_q_ready = m_q_ready & ~stall, m_q_payload = s_q_payload; zero added latency, no buffering.
REQ-015 SHALL on request fire with s_q_wb=1 increment outstanding and set pend[s_q_rd] (and pend[rd+1 mod NumRegs] if s_q_dual); rd==0 bits never set.
REQ-016 SHALL not count or mark requests with s_q_wb=0.
REQ-017 SHALL pass responses combinationally: s_p_* = m_p_*, m_p_ready = s_p_ready.
REQ-018 SHALL on response fire decrement outstanding and clear pend[m_p_rd] (and rd+1 mod NumRegs if m_p_dual).
REQ-019 SHALL on simultaneous request and response fire leave outstanding unchanged and apply both bitmap updates; clear uses the current bitmap, so an issue to a register cleared in the same cycle stalls one cycle (no bypass).
REQ-020 SHALL on response fire with outstanding==0, or with pend[m_p_rd]==0 for m_p_rd!=0, still forward it, hold outstanding at 0 (no wrap), and set err_o sticky until reset.
REQ-021 SHALL implement FSM IDLE->DRAIN on flush_i=1; DRAIN->DONE when outstanding==0; DONE->IDLE after one cycle; flush_done_o=1 only in DONE.
REQ-022 SHALL take IDLE->DONE directly when flush_i=1 and outstanding==0.
REQ-023 SHALL ignore flush_i outside IDLE; DRAIN and DONE block new issue via REQ-013.
REQ-024 SHALL drive busy_o = (outstanding!=0) | fsm!=IDLE; outstanding_o/pending_o registered state.

Reset
REQ-025 SHALL while rst_n=1 asynchronously force outstanding=0, pend=0, err_o=0, FSM=IDLE, flush_done_o=0, busy_o=0; in-flight tracking is discarded mid-operation.
REQ-026 SHALL after reset deassertion accept a request on the first rising edge.

Verification
REQ-027 SHALL cover: 4 wb requests rd=1..4, m_q_ready=1, no responses -> outstanding_o=4, pending_o=0x1E, 5th request rd=5 stalls (s_q_ready=0).
REQ-028 SHALL cover: pend[7]=1, request rd=7 wb=1 -> stall; response rd=7 fires -> next cycle request issues, outstanding unchanged across the two cycles.
REQ-029 SHALL cover: dual request rd=31 -> pend bits 31 and 0 not set for 0 (only 31 set), dual response rd=31 clears bit 31, outstanding 1->0.
REQ-030 SHALL cover: response at outstanding=0 -> forwarded to s_p, outstanding_o=0, err_o=1 stays set.
REQ-031 SHALL cover: 2 outstanding, flush_i pulse -> s_q_ready=0, after both responses flush_done_o=1 for exactly one cycle, then issue resumes.
REQ-032 SHALL cover: rst_n=1 asserted with 3 outstanding mid-cycle -> outstanding_o=0, pending_o=0 immediately, before next clock edge.

Source files
------------

// File: rtl/acc_issue_tracker.sv
// Tracks in-flight accelerator requests that write back to the register file, stalling
// issue on scoreboard hazards or a full window, and drains all of them on a flush.
module acc_issue_tracker #(
    parameter int DataWidth      = 32,
    parameter int PayloadWidth   = 136,
    parameter int MaxOutstanding = 4,
    parameter int NumRegs        = 32,
    localparam int RdWidth       = (NumRegs > 1) ? $clog2(NumRegs) : 1,
    localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n,

    input  logic                    s_q_valid,
    output logic                    s_q_ready,
    input  logic [PayloadWidth-1:0] s_q_payload,
    input  logic [RdWidth-1:0]      s_q_rd,
    input  logic                    s_q_wb,
    input  logic                    s_q_dual,

    output logic                    m_q_valid,
    input  logic                    m_q_ready,
    output logic [PayloadWidth-1:0] m_q_payload,

    input  logic                    m_p_valid,
    output logic                    m_p_ready,
    input  logic [DataWidth-1:0]    m_p_data0,
    input  logic [DataWidth-1:0]    m_p_data1,
    input  logic [RdWidth-1:0]      m_p_rd,
    input  logic                    m_p_dual,
    input  logic                    m_p_error,

    output logic                    s_p_valid,
    input  logic                    s_p_ready,
    output logic [DataWidth-1:0]    s_p_data0,
    output logic [DataWidth-1:0]    s_p_data1,
    output logic [RdWidth-1:0]      s_p_rd,
    output logic                    s_p_dual,
    output logic                    s_p_error,

    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [CntWidth-1:0]     outstanding_o,
    output logic [NumRegs-1:0]      pending_o,
    output logic [1:0]              fsm_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready from the same side, and payload is only meaningful with valid.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [CntWidth-1:0]  outstanding;
    logic [NumRegs-1:0]   pend;
    logic [NumRegs-1:0]   pend_nxt;
    logic                 err_q;
    logic                 flush_done_q;

    logic [RdWidth-1:0]   req_rd_hi;
    logic [RdWidth-1:0]   rsp_rd_hi;
    logic                 hazard;
    logic                 full;
    logic                 stall;
    logic                 req_fire;
    logic                 req_track;
    logic                 rsp_fire;
    logic                 cnt_inc;
    logic                 cnt_dec;
    logic                 rsp_bad;

    function automatic logic [RdWidth-1:0] next_rd(input logic [RdWidth-1:0] rd);
        if (int'(rd) == NumRegs - 1) return '0;
        else return rd + RdWidth'(1);
    endfunction

    assign req_rd_hi = next_rd(s_q_rd);
    assign rsp_rd_hi = next_rd(m_p_rd);

    assign hazard    = s_q_wb & (pend[s_q_rd] | (s_q_dual & pend[req_rd_hi]));
    assign full      = (outstanding == CntWidth'(MaxOutstanding)) & s_q_wb;
    assign stall     = full | hazard | (state != IDLE);

    assign m_q_valid   = s_q_valid & ~stall;
    assign s_q_ready   = m_q_ready & ~stall;
    assign m_q_payload = s_q_payload;

    assign s_p_valid = m_p_valid;
    assign m_p_ready = s_p_ready;
    assign s_p_data0 = m_p_data0;
    assign s_p_data1 = m_p_data1;
    assign s_p_rd    = m_p_rd;
    assign s_p_dual  = m_p_dual;
    assign s_p_error = m_p_error;

    assign req_fire  = s_q_valid & s_q_ready;
    assign req_track = req_fire & s_q_wb;
    assign rsp_fire  = m_p_valid & s_p_ready;
    assign cnt_inc   = req_track;
    assign cnt_dec   = rsp_fire & (outstanding != '0);
    // A response nobody is waiting for is still forwarded; it only flags the error.
    assign rsp_bad   = rsp_fire & ((outstanding == '0) | ((m_p_rd != '0) & ~pend[m_p_rd]));

    // Clears read the current bitmap, so a same-cycle re-issue to a cleared rd was already stalled.
    always_comb begin
        pend_nxt = pend;
        if (rsp_fire) begin
            pend_nxt[m_p_rd] = 1'b0;
            if (m_p_dual) pend_nxt[rsp_rd_hi] = 1'b0;
        end
        if (req_track) begin
            pend_nxt[s_q_rd] = 1'b1;
            if (s_q_dual) pend_nxt[req_rd_hi] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            outstanding <= '0;
            pend        <= '0;
            err_q       <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (rsp_bad) err_q <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   outstanding <= outstanding + CntWidth'(1);
                2'b01:   outstanding <= outstanding - CntWidth'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        if (outstanding == '0) begin
                            state        <= DONE;
                            flush_done_q <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state        <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign flush_done_o  = flush_done_q;
    assign busy_o        = (outstanding != '0) | (state != IDLE);
    assign err_o         = err_q;
    assign outstanding_o = outstanding;
    assign pending_o     = pend;
    assign fsm_state_o   = state;

endmodule

// File: tb/tb_acc_issue_tracker.sv
// Directed bench for acc_issue_tracker: issue window, hazards, dual rd wrap, spurious
// responses, flush draining and asynchronous reset, checked against hand-computed values.
module tb_acc_issue_tracker;

    localparam int DW  = 32;
    localparam int PW  = 136;
    localparam int RW  = 5;
    localparam int CW  = 3;
    localparam int NR  = 32;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_q_valid = 1'b0;
    logic          s_q_ready;
    logic [PW-1:0] s_q_payload = '0;
    logic [RW-1:0] s_q_rd = '0;
    logic          s_q_wb = 1'b0;
    logic          s_q_dual = 1'b0;
    logic          m_q_valid;
    logic          m_q_ready = 1'b1;
    logic [PW-1:0] m_q_payload;
    logic          m_p_valid = 1'b0;
    logic          m_p_ready;
    logic [DW-1:0] m_p_data0 = '0;
    logic [DW-1:0] m_p_data1 = '0;
    logic [RW-1:0] m_p_rd = '0;
    logic          m_p_dual = 1'b0;
    logic          m_p_error = 1'b0;
    logic          s_p_valid;
    logic          s_p_ready = 1'b1;
    logic [DW-1:0] s_p_data0;
    logic [DW-1:0] s_p_data1;
    logic [RW-1:0] s_p_rd;
    logic          s_p_dual;
    logic          s_p_error;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic          busy_o;
    logic          err_o;
    logic [CW-1:0] outstanding_o;
    logic [NR-1:0] pending_o;
    logic [1:0]    fsm_state_o;

    int n_vec = 0;
    int n_err = 0;

    acc_issue_tracker dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .s_q_valid(s_q_valid), .s_q_ready(s_q_ready), .s_q_payload(s_q_payload),
        .s_q_rd(s_q_rd), .s_q_wb(s_q_wb), .s_q_dual(s_q_dual),
        .m_q_valid(m_q_valid), .m_q_ready(m_q_ready), .m_q_payload(m_q_payload),
        .m_p_valid(m_p_valid), .m_p_ready(m_p_ready), .m_p_data0(m_p_data0),
        .m_p_data1(m_p_data1), .m_p_rd(m_p_rd), .m_p_dual(m_p_dual), .m_p_error(m_p_error),
        .s_p_valid(s_p_valid), .s_p_ready(s_p_ready), .s_p_data0(s_p_data0),
        .s_p_data1(s_p_data1), .s_p_rd(s_p_rd), .s_p_dual(s_p_dual), .s_p_error(s_p_error),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .busy_o(busy_o), .err_o(err_o),
        .outstanding_o(outstanding_o), .pending_o(pending_o), .fsm_state_o(fsm_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic [RW-1:0] rd, input logic wb, input logic dual);
        s_q_valid = 1'b1;
        s_q_rd    = rd;
        s_q_wb    = wb;
        s_q_dual  = dual;
    endtask

    task automatic rsp(input logic [RW-1:0] rd, input logic dual);
        m_p_valid = 1'b1;
        m_p_rd    = rd;
        m_p_dual  = dual;
        m_p_data0 = 32'hA000_0000 | 32'(rd);
        m_p_data1 = 32'hB000_0000 | 32'(rd);
    endtask

    task automatic idle_in();
        s_q_valid = 1'b0;
        s_q_wb    = 1'b0;
        s_q_dual  = 1'b0;
        m_p_valid = 1'b0;
        m_p_dual  = 1'b0;
    endtask

    initial begin
        // Reset state while rst_n is high
        #2;
        check("rst_outstanding", PW'(outstanding_o), PW'(0));
        check("rst_pending", PW'(pending_o), PW'(0));
        check("rst_busy", PW'(busy_o), PW'(0));
        check("rst_err", PW'(err_o), PW'(0));
        check("rst_flush_done", PW'(flush_done_o), PW'(0));
        step();
        rst_n = 1'b0;

        // Non-writeback request is forwarded but not tracked
        s_q_payload = {8'hC3, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        req(5'd6, 1'b0, 1'b0);
        settle();
        check("nowb_m_q_valid", PW'(m_q_valid), PW'(1));
        check("payload_pass", m_q_payload, {8'hC3, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
        step();
        check("nowb_outstanding", PW'(outstanding_o), PW'(0));
        check("nowb_pending", PW'(pending_o), PW'(0));

        // Fill the window with rd=1..4, then rd=5 must stall
        for (int i = 1; i <= 4; i++) begin
            req(RW'(i), 1'b1, 1'b0);
            settle();
            check("fill_s_q_ready", PW'(s_q_ready), PW'(1));
            step();
        end
        check("full_outstanding", PW'(outstanding_o), PW'(4));
        check("full_pending", PW'(pending_o), PW'(32'h0000_001E));
        check("full_busy", PW'(busy_o), PW'(1));
        req(5'd5, 1'b1, 1'b0);
        settle();
        check("full_s_q_ready", PW'(s_q_ready), PW'(0));
        check("full_m_q_valid", PW'(m_q_valid), PW'(0));
        m_q_ready = 1'b1;
        idle_in();
        for (int i = 1; i <= 4; i++) begin
            rsp(RW'(i), 1'b0);
            settle();
            check("drain_s_p_rd", PW'(s_p_rd), PW'(i));
            check("drain_s_p_data0", PW'(s_p_data0), PW'(32'hA000_0000 | i));
            step();
        end
        idle_in();
        settle();
        check("drain_outstanding", PW'(outstanding_o), PW'(0));
        check("drain_pending", PW'(pending_o), PW'(0));
        check("drain_err", PW'(err_o), PW'(0));

        // Hazard on rd=7 resolves one cycle after the response
        req(5'd7, 1'b1, 1'b0);
        step();
        check("haz_pending", PW'(pending_o), PW'(32'h0000_0080));
        settle();
        check("haz_stall", PW'(s_q_ready), PW'(0));
        step();
        rsp(5'd7, 1'b0);
        settle();
        check("haz_stall_on_clear", PW'(s_q_ready), PW'(0));
        check("haz_out_before", PW'(outstanding_o), PW'(1));
        step();
        m_p_valid = 1'b0;
        settle();
        check("haz_ready_after", PW'(s_q_ready), PW'(1));
        step();
        check("haz_out_after", PW'(outstanding_o), PW'(1));
        check("haz_pending_after", PW'(pending_o), PW'(32'h0000_0080));
        idle_in();
        rsp(5'd7, 1'b0);
        step();
        idle_in();

        // Simultaneous issue rd=3 and response rd=2
        req(5'd2, 1'b1, 1'b0);
        step();
        req(5'd3, 1'b1, 1'b0);
        rsp(5'd2, 1'b0);
        step();
        check("sim_outstanding", PW'(outstanding_o), PW'(1));
        check("sim_pending", PW'(pending_o), PW'(32'h0000_0008));
        idle_in();
        rsp(5'd3, 1'b0);
        step();
        idle_in();

        // Dual rd=31 wraps to rd 0, which is never marked
        req(5'd31, 1'b1, 1'b1);
        step();
        idle_in();
        check("dual_pending", PW'(pending_o), PW'(32'h8000_0000));
        check("dual_out_set", PW'(outstanding_o), PW'(1));
        rsp(5'd31, 1'b1);
        settle();
        check("dual_s_p_dual", PW'(s_p_dual), PW'(1));
        check("dual_s_p_data1", PW'(s_p_data1), PW'(32'hB000_001F));
        step();
        idle_in();
        check("dual_pending_clr", PW'(pending_o), PW'(0));
        check("dual_out_clr", PW'(outstanding_o), PW'(0));
        check("dual_err", PW'(err_o), PW'(0));

        // Spurious response at outstanding=0
        rsp(5'd5, 1'b0);
        m_p_error = 1'b1;
        settle();
        check("spur_s_p_valid", PW'(s_p_valid), PW'(1));
        check("spur_m_p_ready", PW'(m_p_ready), PW'(1));
        check("spur_s_p_error", PW'(s_p_error), PW'(1));
        step();
        idle_in();
        m_p_error = 1'b0;
        check("spur_outstanding", PW'(outstanding_o), PW'(0));
        check("spur_err", PW'(err_o), PW'(1));
        step();
        check("spur_err_sticky", PW'(err_o), PW'(1));

        // Flush with two outstanding
        req(5'd10, 1'b1, 1'b0);
        step();
        req(5'd11, 1'b1, 1'b0);
        step();
        idle_in();
        check("flush_out2", PW'(outstanding_o), PW'(2));
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        req(5'd12, 1'b1, 1'b0);
        settle();
        check("flush_block", PW'(s_q_ready), PW'(0));
        check("flush_busy", PW'(busy_o), PW'(1));
        check("flush_state", PW'(fsm_state_o), PW'(1));
        rsp(5'd10, 1'b0);
        step();
        rsp(5'd11, 1'b0);
        step();
        m_p_valid = 1'b0;
        check("flush_drained", PW'(outstanding_o), PW'(0));
        check("flush_not_done_yet", PW'(flush_done_o), PW'(0));
        check("flush_still_block", PW'(s_q_ready), PW'(0));
        step();
        check("flush_done", PW'(flush_done_o), PW'(1));
        check("flush_done_block", PW'(s_q_ready), PW'(0));
        step();
        check("flush_done_1cyc", PW'(flush_done_o), PW'(0));
        check("flush_resume", PW'(s_q_ready), PW'(1));
        step();
        check("flush_resume_out", PW'(outstanding_o), PW'(1));

        // Asynchronous reset with three outstanding
        req(5'd13, 1'b1, 1'b0);
        step();
        req(5'd14, 1'b1, 1'b0);
        step();
        idle_in();
        check("pre_rst_out", PW'(outstanding_o), PW'(3));
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst_out", PW'(outstanding_o), PW'(0));
        check("async_rst_pend", PW'(pending_o), PW'(0));
        check("async_rst_err", PW'(err_o), PW'(0));
        check("async_rst_busy", PW'(busy_o), PW'(0));
        step();
        rst_n = 1'b0;
        req(5'd3, 1'b1, 1'b0);
        step();
        idle_in();
        check("post_rst_issue", PW'(outstanding_o), PW'(1));
        rsp(5'd3, 1'b0);
        step();
        idle_in();

        // Flush with nothing outstanding goes straight to DONE
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("direct_done", PW'(flush_done_o), PW'(1));
        step();
        check("direct_done_clr", PW'(flush_done_o), PW'(0));
        check("direct_idle_busy", PW'(busy_o), PW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
